// File: rtl/detector_jogada_pkg.sv
// Shared types and helpers for the player-move detector (state codes, default
// debounce length, counter sizing, one-hot helpers).
package detector_jogada_pkg;

    localparam int DEBOUNCE_PADRAO = 50000;

    typedef enum logic [3:0] {
        ESPERA   = 4'd0,
        FILTRA   = 4'd1,
        VALIDA   = 4'd2,
        REGISTRA = 4'd3,
`ifdef DETECTOR_JOGADA_INVALIDA_EN
        INVALIDA = 4'd4,
`endif
        SOLTA    = 4'd5
    } estado_t;

    // Width that can hold 0..n-1; n is at least 2.
    function automatic int largura_contador(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [3:0] bit_menor(input logic [3:0] v);
        return v & (~v + 4'd1);
    endfunction

    function automatic logic eh_one_hot(input logic [3:0] v);
        return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for asynchronous inputs, width-parameterized.
module sincronizador #(
    parameter int LARGURA = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LARGURA-1:0] i_d,
    output logic [LARGURA-1:0] o_q
);

    logic [LARGURA-1:0] r_meta;
    logic [LARGURA-1:0] r_sinc;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_meta <= '0;
            r_sinc <= '0;
        end else begin
            r_meta <= i_d;
            r_sinc <= r_meta;
        end
    end

    assign o_q = r_sinc;

endmodule

// File: rtl/detector_jogada.sv
// Debounced one-hot move detector for a 4-key player panel.
// Define DETECTOR_JOGADA_INVALIDA_EN to flag multi-key presses on jogada_invalida;
// otherwise the lowest-index pressed key is accepted.
module detector_jogada
    import detector_jogada_pkg::*;
#(
    parameter int DEBOUNCE_CICLOS = DEBOUNCE_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] chaves,
    input  logic       habilita,
    input  logic       zeraJ,
    output logic [3:0] jogada,
    output logic       jogada_feita,
`ifdef DETECTOR_JOGADA_INVALIDA_EN
    output logic       jogada_invalida,
`endif
    output logic       db_tem_jogada,
    output logic [3:0] db_estado
);

    localparam int              CW      = largura_contador(DEBOUNCE_CICLOS);
    localparam logic [CW-1:0]   CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0]   CNT_UM  = CW'(1);

    logic [3:0]    w_s;
    estado_t       r_estado, w_prox;
    logic [3:0]    r_cand,   w_cand;
    logic [CW-1:0] r_cnt,    w_cnt;
    logic [3:0]    r_jogada, w_jogada;
    logic          r_hab;

    sincronizador #(.LARGURA(4)) u_sinc (
        .clock (clock),
        .reset (reset),
        .i_d   (chaves),
        .o_q   (w_s)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= ESPERA;
            r_cand   <= '0;
            r_cnt    <= '0;
            r_jogada <= '0;
            r_hab    <= 1'b0;
        end else begin
            r_estado <= w_prox;
            r_cand   <= w_cand;
            r_cnt    <= w_cnt;
            r_jogada <= w_jogada;
            r_hab    <= habilita;
        end
    end

    always_comb begin
        w_prox   = r_estado;
        w_cand   = r_cand;
        w_cnt    = r_cnt;
        w_jogada = r_jogada;
        // Clear first so a load in REGISTRA overrides it in the same cycle.
        if (zeraJ)
            w_jogada = '0;
        case (r_estado)
            ESPERA: begin
                if (r_hab && (w_s != 4'd0)) begin
                    w_cand = w_s;
                    w_cnt  = '0;
                    w_prox = FILTRA;
                end
            end
            FILTRA: begin
                if (!r_hab || (w_s != r_cand))
                    w_prox = ESPERA;
                else if (r_cnt == CNT_FIM)
                    w_prox = VALIDA;
                else
                    w_cnt = r_cnt + CNT_UM;
            end
            VALIDA: begin
`ifdef DETECTOR_JOGADA_INVALIDA_EN
                w_prox = eh_one_hot(r_cand) ? REGISTRA : INVALIDA;
`else
                w_cand = bit_menor(r_cand);
                w_prox = REGISTRA;
`endif
            end
            REGISTRA: begin
                w_jogada = r_cand;
                w_cnt    = '0;
                w_prox   = SOLTA;
            end
`ifdef DETECTOR_JOGADA_INVALIDA_EN
            INVALIDA: begin
                w_cnt  = '0;
                w_prox = SOLTA;
            end
`endif
            SOLTA: begin
                // Release must be continuous; any key restarts the count.
                if (w_s != 4'd0)
                    w_cnt = '0;
                else if (r_cnt == CNT_FIM)
                    w_prox = ESPERA;
                else
                    w_cnt = r_cnt + CNT_UM;
            end
            default: w_prox = ESPERA;
        endcase
    end

    assign jogada          = r_jogada;
    assign jogada_feita    = (r_estado == REGISTRA);
`ifdef DETECTOR_JOGADA_INVALIDA_EN
    assign jogada_invalida = (r_estado == INVALIDA);
`endif
    assign db_tem_jogada   = |w_s;
    assign db_estado       = r_estado;

endmodule

// File: tb/tb_detector_jogada.sv
// Scoreboard bench for detector_jogada with DEBOUNCE_CICLOS=4.
module tb_detector_jogada;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [3:0] chaves;
    logic       habilita;
    logic       zeraJ;
    logic [3:0] jogada;
    logic       jogada_feita;
    logic       inval;
    logic       db_tem_jogada;
    logic [3:0] db_estado;

    typedef struct {
        int         ciclo;
        bit         invalida;
        logic [3:0] jog;
    } ev_t;

    ev_t        sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         ciclo    = 0;
    bit         pend_ok  = 0;
    logic [3:0] pend_jog = '0;
    bit         prev_pulso = 0;

    detector_jogada #(.DEBOUNCE_CICLOS(D)) dut (
        .clock           (clock),
        .reset           (reset),
        .chaves          (chaves),
        .habilita        (habilita),
        .zeraJ           (zeraJ),
        .jogada          (jogada),
        .jogada_feita    (jogada_feita),
`ifdef DETECTOR_JOGADA_INVALIDA_EN
        .jogada_invalida (inval),
`endif
        .db_tem_jogada   (db_tem_jogada),
        .db_estado       (db_estado)
    );

`ifndef DETECTOR_JOGADA_INVALIDA_EN
    assign inval = 1'b0;
`endif

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) ciclo <= ciclo + 1;

    // Pulse monitor: every pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        bit pulso;
        ev_t e;
        if (pend_ok) begin
            n_checks++;
            if (jogada !== pend_jog) begin
                n_errors++;
                $display("FAIL jogada_after_pulse got=%b want=%b", jogada, pend_jog);
            end
            pend_ok = 0;
        end
        pulso = (jogada_feita === 1'b1) || (inval === 1'b1);
        if (pulso) begin
            n_checks++;
            if (jogada_feita === 1'b1 && inval === 1'b1) begin
                n_errors++;
                $display("FAIL both_pulses feita=1 invalida=1 want=only_one");
            end else if (prev_pulso) begin
                n_errors++;
                $display("FAIL consecutive_pulse at cycle %0d want=single_cycle", ciclo);
            end else if (sb.size() == 0) begin
                n_errors++;
                $display("FAIL pulse_unexpected at cycle %0d feita=%b invalida=%b want=none",
                         ciclo, jogada_feita, inval);
            end else begin
                e = sb.pop_front();
                if (ciclo != e.ciclo || inval !== e.invalida) begin
                    n_errors++;
                    $display("FAIL pulse_timing got cycle=%0d invalida=%b want cycle=%0d invalida=%b",
                             ciclo, inval, e.ciclo, e.invalida);
                end
                pend_jog = e.jog;
                pend_ok  = 1;
            end
        end
        prev_pulso = pulso;
    end

    task automatic espera(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic espera_pulso(input int lat, input bit inv, input logic [3:0] j);
        ev_t e;
        e.ciclo = ciclo + lat;
        e.invalida = inv;
        e.jog = j;
        sb.push_back(e);
    endtask

    task automatic checa_sb_vazio(input string nome);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL %s pulse_missing pending=%0d want=0", nome, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; chaves = '0; habilita = 1'b0; zeraJ = 1'b0;
        espera(3);
        @(negedge clock);
        n_checks++;
        if (jogada !== 4'd0 || jogada_feita !== 1'b0 || inval !== 1'b0 ||
            db_estado !== 4'd0 || db_tem_jogada !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state jogada=%b feita=%b inv=%b estado=%0d tem=%b want all 0",
                     jogada, jogada_feita, inval, db_estado, db_tem_jogada);
        end
        espera(1);
        reset = 1'b1;
        espera(2);
    endtask

    task automatic test_clean_press;
        habilita = 1'b1;
        espera(1);
        chaves = 4'b0100;
        espera_pulso(D + 4, 1'b0, 4'b0100);
        espera(20);
        @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd5 || db_tem_jogada !== 1'b1) begin
            n_errors++;
            $display("FAIL clean_holding estado=%0d tem=%b want 5 1", db_estado, db_tem_jogada);
        end
        espera(1);
        chaves = 4'b0000;
        espera(12);
        @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd0) begin
            n_errors++;
            $display("FAIL clean_idle estado=%0d want 0", db_estado);
        end
        checa_sb_vazio("clean_press");
        espera(1);
    endtask

    task automatic test_bounce;
        for (int i = 0; i < 5; i++) begin
            chaves = (i % 2 == 0) ? 4'b0010 : 4'b0000;
            if (i == 4) espera_pulso(D + 4, 1'b0, 4'b0010);
            espera(2);
        end
        espera(18);
        chaves = 4'b0000;
        espera(12);
        checa_sb_vazio("bounce");
    endtask

    task automatic test_two_keys;
        chaves = 4'b0011;
`ifdef DETECTOR_JOGADA_INVALIDA_EN
        espera_pulso(D + 4, 1'b1, 4'b0010);
`else
        espera_pulso(D + 4, 1'b0, 4'b0001);
`endif
        espera(20);
        chaves = 4'b0000;
        espera(12);
        checa_sb_vazio("two_keys");
    endtask

    task automatic test_gate;
        habilita = 1'b0;
        espera(1);
        chaves = 4'b1000;
        espera(20);
        @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd0 || db_tem_jogada !== 1'b1) begin
            n_errors++;
            $display("FAIL gate_blocked estado=%0d tem=%b want 0 1", db_estado, db_tem_jogada);
        end
        checa_sb_vazio("gate_closed");
        espera(1);
        habilita = 1'b1;
        espera_pulso(D + 3, 1'b0, 4'b1000);
        espera(15);
        chaves = 4'b0000;
        espera(12);
        checa_sb_vazio("gate_open");
    endtask

    task automatic test_zera;
        zeraJ = 1'b1;
        espera(1);
        zeraJ = 1'b0;
        @(negedge clock);
        n_checks++;
        if (jogada !== 4'd0) begin
            n_errors++;
            $display("FAIL zera_clear jogada=%b want 0000", jogada);
        end
        espera(1);
        // zeraJ held through the accept: the load still wins, then clears.
        zeraJ  = 1'b1;
        chaves = 4'b1000;
        espera_pulso(D + 4, 1'b0, 4'b1000);
        espera(10);
        @(negedge clock);
        n_checks++;
        if (jogada !== 4'd0) begin
            n_errors++;
            $display("FAIL zera_after_load jogada=%b want 0000", jogada);
        end
        espera(1);
        zeraJ  = 1'b0;
        chaves = 4'b0000;
        espera(12);
        checa_sb_vazio("zera");
    endtask

    task automatic test_release;
        chaves = 4'b0001;
        espera_pulso(D + 4, 1'b0, 4'b0001);
        espera(12);
        chaves = 4'b0000;
        espera(2);
        chaves = 4'b0001;
        espera(10);
        @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd5) begin
            n_errors++;
            $display("FAIL release_short estado=%0d want 5", db_estado);
        end
        espera(1);
        chaves = 4'b0000;
        espera(10);
        chaves = 4'b0001;
        espera_pulso(D + 4, 1'b0, 4'b0001);
        espera(15);
        chaves = 4'b0000;
        espera(12);
        checa_sb_vazio("release");
    endtask

    task automatic test_reset_mid;
        chaves = 4'b0100;
        espera(4);
        @(negedge clock);
        n_checks++;
        if (db_estado !== 4'd1) begin
            n_errors++;
            $display("FAIL reset_mid_filtra estado=%0d want 1", db_estado);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (jogada !== 4'd0 || jogada_feita !== 1'b0 || db_estado !== 4'd0 ||
            db_tem_jogada !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_async jogada=%b feita=%b estado=%0d tem=%b want 0",
                     jogada, jogada_feita, db_estado, db_tem_jogada);
        end
        espera(2);
        reset = 1'b1;
        espera_pulso(D + 4, 1'b0, 4'b0100);
        espera(15);
        chaves = 4'b0000;
        espera(12);
        checa_sb_vazio("reset_mid");
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_bounce;
        test_two_keys;
        test_gate;
        test_zera;
        test_release;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout cycle=%0d want finish", ciclo);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/detector_jogada.md
DETECTOR_JOGADA -- requirements
Module: detector_jogada

Interface
REQ-001 Parameter DEBOUNCE_CICLOS, default 50000, is the number of consecutive stable synchronized samples required; legal range is 2..2^20.
REQ-002 Port clock, input, 1 bit: the single system clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 Port chaves, input, 4 bits: raw asynchronous player keys, active-high.
REQ-005 Port habilita, input, 1 bit: the player's turn; keys are accepted only while it is high.
REQ-006 Port zeraJ, input, 1 bit: synchronous clear of the registered move.
REQ-007 Port jogada, output, 4 bits: last accepted move, one-hot, held until the next accept or clear.
REQ-008 Port jogada_feita, output, 1 bit: single-cycle accept pulse.
REQ-009 Port jogada_invalida, output, 1 bit: single-cycle pulse on a multi-key press (present only when the REQ-026 macro is defined).
REQ-010 Port db_tem_jogada, output, 1 bit: high when any synchronized key is high.
REQ-011 Port db_estado, output, 4 bits: current FSM state code.

Function
REQ-012 chaves SHALL pass through a 2-flop synchronizer before any other use; the synchronized value is called s.
REQ-013 The FSM SHALL have states ESPERA=0, FILTRA=1, VALIDA=2, REGISTRA=3, INVALIDA=4 and SOLTA=5.
REQ-014 ESPERA: if habilita=1 and s!=0, the block SHALL capture s as the candidate, clear the stability counter and go to FILTRA; otherwise it stays in ESPERA.
REQ-015 FILTRA, stability rule: the counter increments each cycle s equals the candidate. On reaching DEBOUNCE_CICLOS-1 the FSM goes to VALIDA.
REQ-016 FILTRA, abort rule: if s differs from the candidate, the FSM returns to ESPERA. If habilita falls, the FSM returns to ESPERA.
REQ-017 VALIDA: a candidate with exactly one bit set goes to REGISTRA; any other candidate goes to INVALIDA.
REQ-018 REGISTRA: jogada SHALL load the candidate, jogada_feita SHALL be 1 for this cycle only, and the next state is SOLTA.
REQ-019 INVALIDA: jogada_invalida SHALL be 1 for this cycle only, jogada is unchanged, and the next state is SOLTA.
REQ-020 SOLTA: the block SHALL wait until s==0 holds for DEBOUNCE_CICLOS consecutive cycles, then go to ESPERA. Any nonzero s restarts the count.
REQ-021 Latency: with habilita=1 and a clean, held single-key press, jogada_feita SHALL assert exactly DEBOUNCE_CICLOS+4 rising edges after the edge at which chaves changed.
REQ-022 zeraJ=1 SHALL clear jogada to 0 on the next edge. If zeraJ and REGISTRA occur in the same cycle, REGISTRA wins.
REQ-023 jogada_feita and jogada_invalida SHALL never be high together, and SHALL never be high two consecutive cycles.

Reset
REQ-024 While reset=0: FSM in ESPERA, synchronizer, candidate and counter at 0, jogada=0, jogada_feita=0, jogada_invalida=0, db_estado=0.
REQ-025 Reset asserted mid-press SHALL abort immediately. After release, a still-held key SHALL be detected as a fresh press.

Configuration
REQ-026 With DETECTOR_JOGADA_INVALIDA_EN defined: behaviour is as in REQ-017 and REQ-019, and the jogada_invalida port exists.
REQ-027 Without the macro: the INVALIDA state and the jogada_invalida port are absent. VALIDA SHALL accept the lowest-index set bit of the candidate, one-hot encoded, via REGISTRA.

Structure
REQ-028 A shared package detector_jogada_pkg SHALL hold the state enum/codes, the default DEBOUNCE_CICLOS, and the counter width function (clog2).
REQ-029 Sub-module sincronizador (2-flop, width-parameterized, with the same async active-low reset) SHALL be instantiated once for chaves.

Verification (DEBOUNCE_CICLOS=4)
REQ-030 Clean press:
- Stimulus: habilita=1, chaves=0100 held 20 cycles, then 0.
- Response: jogada_feita is one pulse 8 edges after the change, jogada=0100, db_estado reaches 5 and then 0.
REQ-031 Bounce:
- Stimulus: chaves toggles 0010/0000 every 2 cycles for 10 cycles, then 0010 held.
- Response: exactly one jogada_feita, occurring after the hold begins.
REQ-032 Two keys:
- Stimulus: chaves=0011 held.
- Response with the macro: one jogada_invalida pulse and jogada unchanged.
- Response without the macro: jogada_feita with jogada=0001.
REQ-033 Gate:
- Stimulus: habilita=0 with chaves=1000 held 20 cycles.
- Response: no pulse.
- Stimulus: raise habilita while the key is still held.
- Response: pulse 7 edges later.
REQ-034 Release:
- Stimulus: after an accept, release for 2 cycles, re-press 0001, release, then press again.
- Response: no second pulse until the release has held 4 cycles; the later press is accepted.
REQ-035 Reset:
- Stimulus: reset=0 pulse while in FILTRA, key held.
- Response: outputs go to 0 asynchronously; after release, a new accept follows.
